bus_master_0: RTL and testbench



---
 rtl/bus_master_0_if.sv | 35 +++
 rtl/bus_master_0.sv | 137 +++++++++++++
 tb/tb_bus_master_0.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/bus_master_0_if.sv
// rtl/bus_master_0_if.sv - client request/response and ic0 master-side bus bundle
interface bus_master_0_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ic0_c_axi_mst_wr_valid;
  logic        ic0_c_axi_mst_rd_valid;
  logic [31:0] ic0_axi_mst_wr_addr;
  logic [31:0] ic0_axi_mst_wr_data;
  logic [31:0] ic0_axi_mst_rd_addr;
  logic        ic0_c_axi_slv_rd_ready;
  logic [31:0] ic0_axi_slv_rd_data;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
           ic0_c_axi_slv_rd_ready, ic0_axi_slv_rd_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           ic0_c_axi_mst_wr_valid, ic0_c_axi_mst_rd_valid,
           ic0_axi_mst_wr_addr, ic0_axi_mst_wr_data, ic0_axi_mst_rd_addr
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
           ic0_c_axi_slv_rd_ready, ic0_axi_slv_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           ic0_c_axi_mst_wr_valid, ic0_c_axi_mst_rd_valid,
           ic0_axi_mst_wr_addr, ic0_axi_mst_wr_data, ic0_axi_mst_rd_addr
  );
endinterface

// File: rtl/bus_master_0.sv
// rtl/bus_master_0.sv - single-outstanding ic0 initiator with bounded read timeout
module bus_master_0 #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          c_sys_rst,
  bus_master_0_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        wr_valid_q, wr_valid_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] rd_addr_q, rd_addr_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wr_valid_d  = 1'b0;
    rd_valid_d  = rd_valid_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_addr_d   = rd_addr_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          // Misaligned requests never reach the fabric.
          if (bus.req_addr[1:0] != 2'b00) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = bus.req_write ? 32'h0 : ERR_DATA;
          end else if (bus.req_write) begin
            state_d    = WR;
            wr_valid_d = 1'b1;
            wr_addr_d  = bus.req_addr;
            wr_data_d  = bus.req_wdata;
          end else begin
            state_d    = RD;
            rd_valid_d = 1'b1;
            rd_addr_d  = bus.req_addr;
            cnt_d      = 8'd0;
          end
        end
      end
      WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
      end
      RD: begin
        // Ready on the last allowed cycle still counts as success.
        if (bus.ic0_c_axi_slv_rd_ready) begin
          state_d     = RESP;
          rd_valid_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = bus.ic0_axi_slv_rd_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          rd_valid_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = ERR_DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        rd_valid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (c_sys_rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      wr_valid_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_addr_q   <= 32'h0;
      wr_data_q   <= 32'h0;
      rd_addr_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wr_valid_q  <= wr_valid_d;
      rd_valid_q  <= rd_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign bus.req_ready              = (state_q == IDLE);
  assign bus.rsp_valid              = rsp_valid_q;
  assign bus.rsp_rdata              = rsp_rdata_q;
  assign bus.rsp_err                = rsp_err_q;
  assign bus.ic0_c_axi_mst_wr_valid = wr_valid_q;
  assign bus.ic0_c_axi_mst_rd_valid = rd_valid_q;
  assign bus.ic0_axi_mst_wr_addr    = wr_addr_q;
  assign bus.ic0_axi_mst_wr_data    = wr_data_q;
  assign bus.ic0_axi_mst_rd_addr    = rd_addr_q;

endmodule

// File: tb/tb_bus_master_0.sv
// tb/tb_bus_master_0.sv - vector-table bench for bus_master_0 with a stub ic0 read slave
module tb_bus_master_0;
  logic clk = 1'b0;
  logic c_sys_rst;
  int   checks = 0;
  int   errors = 0;

  bus_master_0_if bus ();

  bus_master_0 #(.TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk       (clk),
    .c_sys_rst (c_sys_rst),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] slv_data;
    int          ready_on;
    int          hold;
    int          exp_lat;
    int          exp_wr;
    int          exp_rd;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int lat, wrc, rdc, both, bad_addr, unstable, g;
    logic seen;
    logic [31:0] held;
    g = 0;
    while (!bus.req_ready && g < 20) begin
      step();
      g++;
    end
    chk($sformatf("v%0d_req_ready_idle", idx), {31'h0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = v.write;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    step();
    lat = 1;
    bus.req_valid = 1'b0;
    bus.req_write = ~v.write;
    bus.req_addr  = 32'hFFFF_FFFC;
    bus.req_wdata = 32'h0BAD_0BAD;
    wrc = 0; rdc = 0; both = 0; bad_addr = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.ic0_c_axi_mst_wr_valid && bus.ic0_c_axi_mst_rd_valid) both++;
      if (bus.ic0_c_axi_mst_wr_valid) begin
        wrc++;
        if (bus.ic0_axi_mst_wr_addr !== v.addr || bus.ic0_axi_mst_wr_data !== v.wdata) bad_addr++;
      end
      if (bus.ic0_c_axi_mst_rd_valid) begin
        rdc++;
        if (bus.ic0_axi_mst_rd_addr !== v.addr) bad_addr++;
        bus.ic0_c_axi_slv_rd_ready = (rdc == v.ready_on);
        bus.ic0_axi_slv_rd_data    = (rdc == v.ready_on) ? v.slv_data : 32'hCAFE_F00D;
      end else begin
        bus.ic0_c_axi_slv_rd_ready = 1'b0;
      end
      if (bus.rsp_valid) begin
        seen = 1'b1;
        break;
      end
      step();
      lat++;
    end
    bus.ic0_c_axi_slv_rd_ready = 1'b0;
    chk($sformatf("v%0d_rsp_seen", idx), {31'h0, seen}, 32'd1);
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_wr_cycles", idx), wrc, v.exp_wr);
    chk($sformatf("v%0d_rd_cycles", idx), rdc, v.exp_rd);
    chk($sformatf("v%0d_wr_rd_overlap", idx), both, 32'd0);
    chk($sformatf("v%0d_bus_addr_data", idx), bad_addr, 32'd0);
    chk($sformatf("v%0d_rsp_err", idx), {31'h0, bus.rsp_err}, {31'h0, v.exp_err});
    chk($sformatf("v%0d_rsp_rdata", idx), bus.rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d_req_ready_busy", idx), {31'h0, bus.req_ready}, 32'd0);
    unstable = 0;
    held = bus.rsp_rdata;
    for (int h = 0; h < v.hold; h++) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h0000_0010;
      step();
      if (!bus.rsp_valid || bus.rsp_rdata !== held || bus.rsp_err !== v.exp_err ||
          bus.req_ready || bus.ic0_c_axi_mst_wr_valid || bus.ic0_c_axi_mst_rd_valid) unstable++;
    end
    bus.req_valid = 1'b0;
    if (v.hold > 0) chk($sformatf("v%0d_backpressure_stable", idx), unstable, 32'd0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk($sformatf("v%0d_rsp_valid_drop", idx), {31'h0, bus.rsp_valid}, 32'd0);
    chk($sformatf("v%0d_req_ready_after", idx), {31'h0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    int bad;
    //           wr    addr          wdata         slv_data      rdy hold lat wr  rd  err   rdata
    vecs[0] = '{1'b1, 32'h80030014, 32'h000000A5, 32'h0,        0,  0,   2,  1,  0,  1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h80030020, 32'h0,        32'h0000005A, 1,  0,   2,  0,  1,  1'b0, 32'h0000005A};
    vecs[2] = '{1'b0, 32'h80030024, 32'h0,        32'h12345678, 4,  0,   5,  0,  4,  1'b0, 32'h12345678};
    vecs[3] = '{1'b0, 32'h80030028, 32'h0,        32'hA5A5F00F, 16, 0,   17, 0,  16, 1'b0, 32'hA5A5F00F};
    vecs[4] = '{1'b0, 32'h90000000, 32'h0,        32'h0,        0,  0,   17, 0,  16, 1'b1, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 32'h80030002, 32'h0,        32'h0,        1,  0,   1,  0,  0,  1'b1, 32'hDEADBEEF};
    vecs[6] = '{1'b1, 32'h80030002, 32'h11112222, 32'h0,        0,  0,   1,  0,  0,  1'b1, 32'h0};
    vecs[7] = '{1'b0, 32'h80030030, 32'h0,        32'h00000077, 2,  10,  3,  0,  2,  1'b0, 32'h00000077};

    c_sys_rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    bus.ic0_c_axi_slv_rd_ready = 1'b0;
    bus.ic0_axi_slv_rd_data    = 32'h0;
    repeat (3) step();
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'h0, bus.rsp_err}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_wr_valid", {31'h0, bus.ic0_c_axi_mst_wr_valid}, 32'd0);
    chk("rst_rd_valid", {31'h0, bus.ic0_c_axi_mst_rd_valid}, 32'd0);
    chk("rst_wr_addr", bus.ic0_axi_mst_wr_addr, 32'h0);
    chk("rst_wr_data", bus.ic0_axi_mst_wr_data, 32'h0);
    chk("rst_rd_addr", bus.ic0_axi_mst_rd_addr, 32'h0);
    c_sys_rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

    chk("idle_wr_addr_hold", bus.ic0_axi_mst_wr_addr, 32'h80030014);
    chk("idle_wr_data_hold", bus.ic0_axi_mst_wr_data, 32'h000000A5);

    // Reset while a read is stalled on the fabric.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h40000000;
    step();
    bus.req_valid = 1'b0;
    repeat (3) step();
    chk("midrd_rd_valid", {31'h0, bus.ic0_c_axi_mst_rd_valid}, 32'd1);
    c_sys_rst = 1'b1;
    step();
    chk("midrd_rst_rd_valid", {31'h0, bus.ic0_c_axi_mst_rd_valid}, 32'd0);
    chk("midrd_rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
    c_sys_rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.rsp_valid || bus.ic0_c_axi_mst_rd_valid || !bus.req_ready) bad++;
    end
    chk("midrd_after_rst_quiet", bad, 32'd0);
    chk("midrd_after_rst_req_ready", {31'h0, bus.req_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
